// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker that sits beside the traffic-light controller and watches
//   its lamp outputs. Each clock it decodes the current phase, flags illegal
//   lamp encodings, conflicting greens/yellows, out-of-order phase changes and
//   wrong phase durations (measured in ticks), and counts completed cycles.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   tick              : the controller's single-cycle enable pulse
//   ns_g/ns_y/ns_r    : north-south lamps
//   ew_g/ew_y/ew_r    : east-west lamps
//   phase             : decoded phase (0=NSG 1=NSY 2=EWG 3=EWY), holds when invalid
//   phase_valid       : lamps formed a legal phase on the last sample
//   locked            : tracker has seen a phase boundary and is checking timing
//   cycle_count       : completed EWY->NSG transitions while locked (wraps)
//   err_encoding      : sticky, a direction was not one-hot
//   err_conflict      : sticky, both directions non-red at once
//   err_sequence      : sticky, illegal phase-to-phase transition
//   err_timing        : sticky, a phase lasted the wrong number of ticks
//   err_any           : OR of the four sticky flags
module traffic_light_monitor #(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ns_g,
    input  logic             ns_y,
    input  logic             ns_r,
    input  logic             ew_g,
    input  logic             ew_y,
    input  logic             ew_r,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_encoding,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_any
);

    typedef enum logic {S_SYNC, S_TRACK} state_t;

    localparam logic [1:0]       P_NSG   = 2'd0;
    localparam logic [1:0]       P_EWY   = 2'd3;
    localparam logic [CNT_W-1:0] GRN_C   = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YEL_C   = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             err_enc_q, err_enc_d;
    logic             err_conf_q, err_conf_d;
    logic             err_seq_q, err_seq_d;
    logic             err_tim_q, err_tim_d;
    logic             err_any_q, err_any_d;

    logic             ns_oh, ew_oh, cur_valid;
    logic [1:0]       cur_phase, next_phase;
    logic [CNT_W-1:0] cnt_inc, cnt_first, exp_ticks;

    always_comb begin
        // Exactly one of three: odd parity rules out 0 and 2, and not all three.
        ns_oh = (ns_g ^ ns_y ^ ns_r) & ~(ns_g & ns_y & ns_r);
        ew_oh = (ew_g ^ ew_y ^ ew_r) & ~(ew_g & ew_y & ew_r);

        cur_valid = 1'b1;
        cur_phase = P_NSG;
        if (!(ns_oh && ew_oh))   cur_valid = 1'b0;
        else if (ns_g && ew_r)   cur_phase = 2'd0;
        else if (ns_y && ew_r)   cur_phase = 2'd1;
        else if (ew_g && ns_r)   cur_phase = 2'd2;
        else if (ew_y && ns_r)   cur_phase = 2'd3;
        else                     cur_valid = 1'b0;   // all red, or a conflict

        next_phase = phase_q + 2'd1;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // A tick on the edge where the new phase first appears belongs to it.
        cnt_first  = tick ? CNT_W'(1) : '0;
        exp_ticks  = phase_q[0] ? YEL_C : GRN_C;

        state_d       = state_q;
        phase_d       = phase_q;
        phase_valid_d = cur_valid;
        cnt_d         = cnt_q;
        cyc_d         = cyc_q;
        err_enc_d     = err_enc_q | ~(ns_oh & ew_oh);
        err_conf_d    = err_conf_q | ((ns_g | ns_y) & (ew_g | ew_y));
        err_seq_d     = err_seq_q;
        err_tim_d     = err_tim_q;

        if (!cur_valid) begin
            // Lost the phase: resynchronise, abandoned phase is not timed.
            state_d = S_SYNC;
            cnt_d   = '0;
        end else begin
            phase_d = cur_phase;
            if (!phase_valid_q || cur_phase == phase_q) begin
                // No boundary seen (same phase, or first valid sample after
                // an invalid one, where the counter is already cleared).
                cnt_d = tick ? cnt_inc : cnt_q;
                if (state_q == S_TRACK && cnt_d > exp_ticks)
                    err_tim_d = 1'b1;   // overstay caught before the change
            end else if (cur_phase == next_phase) begin
                cnt_d   = cnt_first;
                state_d = S_TRACK;
                // The phase in force when locking was partial: only check
                // phases that began while already tracking.
                if (state_q == S_TRACK) begin
                    if (cnt_q != exp_ticks) err_tim_d = 1'b1;
                    if (phase_q == P_EWY)   cyc_d = cyc_q + 1'b1;
                end
            end else begin
                // Out-of-order jump: the phase history is no longer trusted,
                // so drop back to SYNC until the next legal boundary.
                err_seq_d = 1'b1;
                state_d   = S_SYNC;
                cnt_d     = cnt_first;
            end
        end

        err_any_d = err_enc_d | err_conf_d | err_seq_d | err_tim_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_SYNC;
            phase_q       <= P_NSG;
            phase_valid_q <= 1'b0;
            cnt_q         <= '0;
            cyc_q         <= '0;
            err_enc_q     <= 1'b0;
            err_conf_q    <= 1'b0;
            err_seq_q     <= 1'b0;
            err_tim_q     <= 1'b0;
            err_any_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            cnt_q         <= cnt_d;
            cyc_q         <= cyc_d;
            err_enc_q     <= err_enc_d;
            err_conf_q    <= err_conf_d;
            err_seq_q     <= err_seq_d;
            err_tim_q     <= err_tim_d;
            err_any_q     <= err_any_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign locked       = (state_q == S_TRACK);
    assign cycle_count  = cyc_q;
    assign err_encoding = err_enc_q;
    assign err_conflict = err_conf_q;
    assign err_sequence = err_seq_q;
    assign err_timing   = err_tim_q;
    assign err_any      = err_any_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a table of single-cycle vectors for the
// error/lock corner cases, then a small controller model driving full runs
// (clean run, async reset mid-phase, cycle_count wrap).
module tb_traffic_light_monitor;

    // Lamp patterns as {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
    localparam logic [5:0] L_NSG  = 6'b100_001;
    localparam logic [5:0] L_NSY  = 6'b010_001;
    localparam logic [5:0] L_EWG  = 6'b001_100;
    localparam logic [5:0] L_EWY  = 6'b001_010;
    localparam logic [5:0] L_ALLR = 6'b001_001;
    localparam logic [5:0] L_CONF = 6'b100_100;
    localparam logic [5:0] L_BAD  = 6'b110_001;

    // Error nibble {encoding, conflict, sequence, timing}
    localparam logic [3:0] E_NONE = 4'b0000;
    localparam logic [3:0] E_TIM  = 4'b0001;
    localparam logic [3:0] E_SEQ  = 4'b0010;
    localparam logic [3:0] E_CONF = 4'b0100;
    localparam logic [3:0] E_ENC  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] lamps = L_NSG;

    logic [1:0] phase;
    logic       phase_valid, locked;
    logic [7:0] cycle_count;
    logic       err_encoding, err_conflict, err_sequence, err_timing, err_any;

    int n_vec = 0;
    int n_bad = 0;

    traffic_light_monitor #(.GREEN_TICKS(5), .YELLOW_TICKS(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_g(lamps[5]), .ns_y(lamps[4]), .ns_r(lamps[3]),
        .ew_g(lamps[2]), .ew_y(lamps[1]), .ew_r(lamps[0]),
        .phase(phase), .phase_valid(phase_valid), .locked(locked),
        .cycle_count(cycle_count),
        .err_encoding(err_encoding), .err_conflict(err_conflict),
        .err_sequence(err_sequence), .err_timing(err_timing), .err_any(err_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r;
        bit          t;
        logic [5:0]  l;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packed view: {phase, phase_valid, locked, cycle_count, enc, conf, seq, tim, any}
    function automatic logic [16:0] pk(input logic [1:0] ph, input bit pv, input bit lk,
                                       input logic [7:0] cyc, input logic [3:0] e);
        return {ph, pv, lk, cyc, e, |e};
    endfunction

    function automatic logic [16:0] got();
        return {phase, phase_valid, locked, cycle_count,
                err_encoding, err_conflict, err_sequence, err_timing, err_any};
    endfunction

    task automatic add(input bit r, input bit t, input logic [5:0] l, input logic [16:0] e);
        vec_t v;
        v.r = r; v.t = t; v.l = l; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] g, input logic [16:0] e);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", name, g, e);
        end
    endtask

    // Controller model: phase index and ticks spent in it.
    int ph = 0;
    int tc = 0;

    function automatic logic [5:0] lamp_of(input int p);
        case (p)
            0:       return L_NSG;
            1:       return L_NSY;
            2:       return L_EWG;
            default: return L_EWY;
        endcase
    endfunction

    task automatic ctl_clk(input bit t);
        tick  = t;
        lamps = lamp_of(ph);
        @(posedge clk);
        #1;
        if (t) begin
            tc++;
            if (tc == ((ph % 2 == 1) ? 2 : 5)) begin
                ph = (ph + 1) % 4;
                tc = 0;
            end
        end
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            ctl_clk(1'b1);
            for (int j = 1; j < gap; j++) ctl_clk(1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; ph = 0; tc = 0; lamps = L_NSG;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Short EWY (1 tick) then NSG: timing error, cycle still counted
        add(1, 0, L_NSG,  pk(0, 0, 0, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 0, 0, E_NONE));
        add(0, 1, L_NSY,  pk(1, 1, 1, 0, E_NONE));
        add(0, 1, L_NSY,  pk(1, 1, 1, 0, E_NONE));
        add(0, 1, L_EWG,  pk(2, 1, 1, 0, E_NONE));
        add(0, 1, L_EWG,  pk(2, 1, 1, 0, E_NONE));
        add(0, 1, L_EWG,  pk(2, 1, 1, 0, E_NONE));
        add(0, 1, L_EWG,  pk(2, 1, 1, 0, E_NONE));
        add(0, 1, L_EWG,  pk(2, 1, 1, 0, E_NONE));
        add(0, 0, L_EWY,  pk(3, 1, 1, 0, E_NONE));
        add(0, 1, L_EWY,  pk(3, 1, 1, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 1, E_TIM));
        add(1, 0, L_NSG,  pk(0, 0, 0, 0, E_NONE));
        // Lock on EWY->NSG (no cycle while syncing), NSG overstays, then NSG->EWG
        add(0, 0, L_EWY,  pk(3, 1, 0, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 0, E_NONE));
        add(0, 1, L_NSG,  pk(0, 1, 1, 0, E_TIM));
        add(0, 0, L_EWG,  pk(2, 1, 0, 0, E_TIM | E_SEQ));
        add(1, 0, L_NSG,  pk(0, 0, 0, 0, E_NONE));
        // Conflict, re-lock, bad encoding, all-red
        add(0, 0, L_NSG,  pk(0, 1, 0, 0, E_NONE));
        add(0, 0, L_NSY,  pk(1, 1, 1, 0, E_NONE));
        add(0, 0, L_CONF, pk(1, 0, 0, 0, E_CONF));
        add(0, 0, L_NSY,  pk(1, 1, 0, 0, E_CONF));
        add(0, 0, L_EWG,  pk(2, 1, 1, 0, E_CONF));
        add(0, 0, L_BAD,  pk(2, 0, 0, 0, E_CONF | E_ENC));
        add(0, 0, L_ALLR, pk(2, 0, 0, 0, E_CONF | E_ENC));
        add(1, 0, L_NSG,  pk(0, 0, 0, 0, E_NONE));

        for (int i = 0; i < vecs.size(); i++) begin
            rst   = vecs[i].r;
            tick  = vecs[i].t;
            lamps = vecs[i].l;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), got(), vecs[i].exp);
        end

        // Clean run: tick every 5 clocks, 40 ticks
        do_reset();
        run_ticks(4, 5);
        ctl_clk(1'b1);
        check("run_prelock", {16'd0, locked}, 17'd0);
        ctl_clk(1'b0);
        check("run_lock", {16'd0, locked}, 17'd1);
        repeat (3) ctl_clk(1'b0);
        run_ticks(35, 5);
        check("run_end", got(), pk(3, 1, 1, 2, E_NONE));

        // Continue into NSY, then reset asynchronously between edges
        run_ticks(8, 5);
        check("mid_nsy", got(), pk(1, 1, 1, 3, E_NONE));
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        #1;
        check("async_rst", got(), pk(0, 0, 0, 0, E_NONE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_ticks(1, 5);
        check("resync", got(), pk(2, 1, 1, 0, E_NONE));
        run_ticks(14, 5);
        check("post_rst_cycle", got(), pk(2, 1, 1, 1, E_NONE));

        // cycle_count wrap with tick every clock
        do_reset();
        run_ticks(255 * 14, 1);
        ctl_clk(1'b0);
        check("cyc_255", got(), pk(0, 1, 1, 255, E_NONE));
        run_ticks(14, 1);
        ctl_clk(1'b0);
        check("cyc_wrap", got(), pk(0, 1, 1, 0, E_NONE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the consumer side of the traffic-light controller's lamp interface.
- Samples the six lamp outputs (ns_g/y/r, ew_g/y/r) and the shared tick each clock, and decodes the current phase.
- Enforces encoding, safety, sequence and per-phase tick durations; raises sticky error flags and counts completed cycles.
- Instantiated beside the controller in benches and on-board debug builds.

Parameters:
GREEN_TICKS, 5, ticks each green phase (NS green, EW green) must last
YELLOW_TICKS, 2, ticks each yellow phase (NS yellow, EW yellow) must last
CNT_W, 8, width of tick-in-phase counter and cycle_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tick  input  1  single-cycle enable pulse, same one the controller consumes
ns_g, ns_y, ns_r  input  1 each  north-south lamps
ew_g, ew_y, ew_r  input  1 each  east-west lamps
phase  output  2  decoded phase: 0=NSG, 1=NSY, 2=EWG, 3=EWY
phase_valid  output  1  lamps form a legal phase this cycle
locked  output  1  tracker has seen a full phase boundary and is checking timing
cycle_count  output  CNT_W  completed EWY->NSG transitions, wraps modulo 2^CNT_W
err_encoding  output  1  sticky: a direction not exactly one-hot
err_conflict  output  1  sticky: both directions non-red simultaneously
err_sequence  output  1  sticky: illegal phase-to-phase transition
err_timing  output  1  sticky: phase duration differed from its parameter
err_any  output  1  OR of the four sticky flags

Behaviour:
- Reset (async, rst=1): phase=0, phase_valid=0, locked=0, cycle_count=0, all err_*=0, internal tick counter=0, prev phase invalid, FSM=SYNC.
- All outputs are registered. Effects of the inputs sampled at edge N are visible after edge N.
- Decode (combinational on inputs, registered to outputs):
  - NSG = ns_g & ew_r
  - NSY = ns_y & ew_r
  - EWG = ew_g & ns_r
  - EWY = ew_y & ns_r
  - Each direction must be exactly one-hot; anything else gives phase_valid=0 and phase holds its last value.
- err_encoding: set when either direction's {g,y,r} is not one-hot.
- err_conflict: set when (ns_g|ns_y) & (ew_g|ew_y). Both flags can set on the same edge.
- Legal order: NSG->NSY->EWG->EWY->NSG. Holding the same phase is legal. Any other change between valid phases sets err_sequence.
- FSM states:
  - SYNC: waiting for the first valid phase change. First change (legal) -> TRACK, locked=1, counter cleared. Illegal change sets err_sequence and stays in SYNC.
  - TRACK: timing checked. Invalid decode -> SYNC, locked=0, counter cleared, no timing check on the abandoned phase.
- Tick accounting:
  - tick=1 at an edge counts toward the phase present on the lamps at that same edge. The controller's advancing tick therefore belongs to the old phase.
  - Counter clears on the edge the new phase is first sampled; a tick on that edge counts as 1 for the new phase.
  - Counter saturates at 2^CNT_W-1.
- Timing check (TRACK only):
  - On a phase change, err_timing sets if the old phase's count != expected (GREEN_TICKS for NSG/EWG, YELLOW_TICKS for NSY/EWY).
  - err_timing also sets immediately when the count exceeds the expected value while still in the phase (overstay, detected one tick early).
  - The phase active when SYNC->TRACK occurs is partial and is never checked.
- cycle_count increments on each legal EWY->NSG change in TRACK, 2^CNT_W-1 wraps to 0.
- Sticky flags clear only on rst. Reset mid-phase returns to SYNC; the partial phase after reset is unchecked.
- tick high for several consecutive cycles counts once per cycle.

Test Plan:
1. Legal controller run with tick every 5 clks, 40 ticks, GREEN=5/YELLOW=2 -> locked=1 after first NS green->yellow change, cycle_count=2, all err_*=0.
2. Force ns_g=1, ew_g=1, ns_r=ew_r=0 for 1 cycle -> err_conflict=1 and err_any=1 after that edge; stays 1 until rst. Also err_encoding=0, phase_valid=0, locked=0.
3. Drive ns_g=1, ns_y=1, ns_r=0, ew_r=1 -> err_encoding=1, phase_valid=0, FSM back in SYNC (locked=0).
4. In TRACK drive NSG then directly EWG -> err_sequence=1; NSG held 6 ticks -> err_timing=1 on the 6th tick edge while phase still NSG.
5. EWY lasting 1 tick then NSG -> err_timing=1 on the NSG edge; cycle_count still increments.
6. Assert rst asynchronously mid-NSY (between edges) -> all outputs 0 immediately. Restart mid-phase -> no err_timing for the partial phase, normal checking after next change.
